anton_neopixel_receiver: RTL and testbench

Decodes a WS2812-style single-wire NeoPixel stream back into channel bytes. It is the receive-side counterpart of the controller's pixel transmitter, and its timing matches that transmitter's 8-slot bit pattern: '0' is 2 slots high, '1' is 5 slots high. It is used for loopback self-test of the controller and for daisy-chain sniffing. Each decoded byte is emitted with its pixel and channel indices, and a frame-done pulse is raised when the latch (reset) low period is detected.

---
 rtl/anton_neopixel_receiver_pkg.sv | 23 ++
 rtl/anton_neopixel_receiver_rx_sync.sv | 32 +++
 rtl/anton_neopixel_receiver.sv | 239 +++++++++++++++++++++++
 tb/tb_anton_neopixel_receiver.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/anton_neopixel_receiver_pkg.sv
// Shared state encoding and default timing for the NeoPixel receive path.
// The defaults assume a 7 MHz clock and the transmitter's 8-slot bit cell.
package anton_neopixel_receiver_pkg;

    typedef enum logic [1:0] {
        ENUM_RX_WAIT_LATCH = 2'd0,
        ENUM_RX_IDLE       = 2'd1,
        ENUM_RX_HIGH       = 2'd2,
        ENUM_RX_LOW        = 2'd3
    } rxState_e;

    localparam int BUFFER_END_DEFAULT    = 63;
    localparam int ONE_THRESHOLD_DEFAULT = 4;
    localparam int MAX_HIGH_DEFAULT      = 7;
    localparam int RESET_CYCLES_DEFAULT  = 350;
    localparam int CNT_BITS_DEFAULT      = 9;

    // Index width for values 0..count-1, never narrower than one bit.
    function automatic int indexBits(input int count);
        return (count <= 2) ? 1 : $clog2(count);
    endfunction

endpackage

// File: rtl/anton_neopixel_receiver_rx_sync.sv
// Two-flop synchronizer for an asynchronous line, with single-cycle
// rise/fall strobes derived from the synchronized level.
module anton_neopixel_rx_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign level_o = sync_q;
    assign rise_o  = sync_q & ~prev_q;
    assign fall_o  = ~sync_q & prev_q;

endmodule

// File: rtl/anton_neopixel_receiver.sv
// WS2812-style stream decoder: measures high/low times of the synchronized
// line, rebuilds bytes MSB first and tags them with pixel/channel indices.
module anton_neopixel_receiver
    import anton_neopixel_receiver_pkg::*;
#(
    parameter int  BUFFER_END    = BUFFER_END_DEFAULT,
    parameter int  ONE_THRESHOLD = ONE_THRESHOLD_DEFAULT,
    parameter int  MAX_HIGH      = MAX_HIGH_DEFAULT,
    parameter int  RESET_CYCLES  = RESET_CYCLES_DEFAULT,
    parameter int  CNT_BITS      = CNT_BITS_DEFAULT,
    localparam int BUFFER_BITS   = indexBits(BUFFER_END + 1)
) (
    input  logic                   clk7mhz,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   neoDataIn,
    output logic [7:0]             byteData,
    output logic                   byteValid,
    output logic [BUFFER_BITS-1:0] pixelIndex,
    output logic [1:0]             channelIndex,
    output logic                   frameDone,
    output logic                   errPulse,
    output logic                   overflow
);

    localparam logic [CNT_BITS-1:0]    CNT_ONE   = CNT_BITS'(1);
    localparam logic [CNT_BITS-1:0]    CNT_MIN   = CNT_BITS'(2);
    localparam logic [CNT_BITS-1:0]    CNT_BIT1  = CNT_BITS'(ONE_THRESHOLD);
    localparam logic [CNT_BITS-1:0]    CNT_MAX   = CNT_BITS'(MAX_HIGH);
    localparam logic [CNT_BITS-1:0]    CNT_SAT   = CNT_BITS'(MAX_HIGH + 1);
    localparam logic [CNT_BITS-1:0]    CNT_LATCH = CNT_BITS'(RESET_CYCLES);
    localparam logic [CNT_BITS-1:0]    CNT_WAIT  = CNT_BITS'(RESET_CYCLES - 1);
    localparam logic [BUFFER_BITS-1:0] PIX_LAST  = BUFFER_BITS'(BUFFER_END);

    logic lineHigh;
    logic lineRise;
    logic lineFall;

    rxState_e               state_q, state_d;
    logic [CNT_BITS-1:0]    cnt_q, cnt_d;
    logic [7:0]             shift_q, shift_d;
    logic [2:0]             bitCnt_q, bitCnt_d;
    logic [BUFFER_BITS-1:0] pix_q, pix_d;
    logic [1:0]             chan_q, chan_d;
    logic                   full_q, full_d;
    logic                   anyByte_q, anyByte_d;
    logic [7:0]             byteData_q, byteData_d;
    logic                   byteValid_q, byteValid_d;
    logic [BUFFER_BITS-1:0] outPix_q, outPix_d;
    logic [1:0]             outChan_q, outChan_d;
    logic                   frameDone_q, frameDone_d;
    logic                   errPulse_q, errPulse_d;
    logic                   overflow_q, overflow_d;

    logic       pulseOk;
    logic       bitValue;
    logic [7:0] shiftIn;

    anton_neopixel_rx_sync uSync (
        .clk_i   (clk7mhz),
        .rst_i   (rst),
        .async_i (neoDataIn),
        .level_o (lineHigh),
        .rise_o  (lineRise),
        .fall_o  (lineFall)
    );

    // In HIGH, cnt_q equals the number of cycles the line has been high.
    assign pulseOk  = (cnt_q >= CNT_MIN) && (cnt_q <= CNT_MAX);
    assign bitValue = (cnt_q >= CNT_BIT1);
    assign shiftIn  = {shift_q[6:0], bitValue};

    always_ff @(posedge clk7mhz) begin
        if (rst) begin
            state_q     <= ENUM_RX_WAIT_LATCH;
            cnt_q       <= '0;
            shift_q     <= '0;
            bitCnt_q    <= '0;
            pix_q       <= '0;
            chan_q      <= '0;
            full_q      <= 1'b0;
            anyByte_q   <= 1'b0;
            byteData_q  <= '0;
            byteValid_q <= 1'b0;
            outPix_q    <= '0;
            outChan_q   <= '0;
            frameDone_q <= 1'b0;
            errPulse_q  <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            bitCnt_q    <= bitCnt_d;
            pix_q       <= pix_d;
            chan_q      <= chan_d;
            full_q      <= full_d;
            anyByte_q   <= anyByte_d;
            byteData_q  <= byteData_d;
            byteValid_q <= byteValid_d;
            outPix_q    <= outPix_d;
            outChan_q   <= outChan_d;
            frameDone_q <= frameDone_d;
            errPulse_q  <= errPulse_d;
            overflow_q  <= overflow_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = ENUM_RX_WAIT_LATCH;
        end else begin
            case (state_q)
                ENUM_RX_WAIT_LATCH: if (!lineHigh && cnt_q == CNT_WAIT) state_d = ENUM_RX_IDLE;
                ENUM_RX_IDLE:       if (lineRise) state_d = ENUM_RX_HIGH;
                ENUM_RX_HIGH:       if (lineFall) state_d = pulseOk ? ENUM_RX_LOW : ENUM_RX_WAIT_LATCH;
                ENUM_RX_LOW: begin
                    if (lineRise) begin
                        state_d = ENUM_RX_HIGH;
                    end else if (cnt_q == CNT_LATCH) begin
                        state_d = ENUM_RX_IDLE;
                    end
                end
                default:            state_d = ENUM_RX_WAIT_LATCH;
            endcase
        end
    end

    always_comb begin
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        bitCnt_d    = bitCnt_q;
        pix_d       = pix_q;
        chan_d      = chan_q;
        full_d      = full_q;
        anyByte_d   = anyByte_q;
        byteData_d  = byteData_q;
        byteValid_d = 1'b0;
        outPix_d    = outPix_q;
        outChan_d   = outChan_q;
        frameDone_d = 1'b0;
        errPulse_d  = 1'b0;
        overflow_d  = overflow_q;

        if (!enable) begin
            cnt_d    = '0;
            shift_d  = '0;
            bitCnt_d = '0;
        end else begin
            case (state_q)
                ENUM_RX_WAIT_LATCH: begin
                    if (lineHigh) begin
                        cnt_d = '0;
                    end else if (cnt_q == CNT_WAIT) begin
                        cnt_d     = '0;
                        shift_d   = '0;
                        bitCnt_d  = '0;
                        pix_d     = '0;
                        chan_d    = '0;
                        full_d    = 1'b0;
                        anyByte_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ENUM_RX_IDLE: begin
                    if (lineRise) cnt_d = CNT_ONE;
                end
                ENUM_RX_HIGH: begin
                    if (lineFall) begin
                        if (!pulseOk) begin
                            errPulse_d = 1'b1;
                            cnt_d      = '0;
                            shift_d    = '0;
                            bitCnt_d   = '0;
                        end else begin
                            cnt_d    = CNT_ONE;
                            shift_d  = shiftIn;
                            bitCnt_d = bitCnt_q + 3'd1;
                            // Once the last channel of BUFFER_END is used, indices freeze.
                            if (bitCnt_q == 3'd7) begin
                                anyByte_d = 1'b1;
                                if (full_q) begin
                                    overflow_d = 1'b1;
                                end else begin
                                    byteValid_d = 1'b1;
                                    byteData_d  = shiftIn;
                                    outPix_d    = pix_q;
                                    outChan_d   = chan_q;
                                    if (chan_q == 2'd2) begin
                                        chan_d = 2'd0;
                                        if (pix_q == PIX_LAST) begin
                                            full_d = 1'b1;
                                        end else begin
                                            pix_d = pix_q + BUFFER_BITS'(1);
                                        end
                                    end else begin
                                        chan_d = chan_q + 2'd1;
                                    end
                                end
                            end
                        end
                    end else if (cnt_q != CNT_SAT) begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ENUM_RX_LOW: begin
                    if (lineRise) begin
                        cnt_d = CNT_ONE;
                    end else if (cnt_q == CNT_LATCH) begin
                        errPulse_d  = (bitCnt_q != 3'd0);
                        frameDone_d = anyByte_q;
                        cnt_d       = '0;
                        shift_d     = '0;
                        bitCnt_d    = '0;
                        pix_d       = '0;
                        chan_d      = '0;
                        full_d      = 1'b0;
                        anyByte_d   = 1'b0;
                        overflow_d  = 1'b0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: cnt_d = '0;
            endcase
        end
    end

    assign byteData     = byteData_q;
    assign byteValid    = byteValid_q;
    assign pixelIndex   = outPix_q;
    assign channelIndex = outChan_q;
    assign frameDone    = frameDone_q;
    assign errPulse     = errPulse_q;
    assign overflow     = overflow_q;

endmodule

// File: tb/tb_anton_neopixel_receiver.sv
// Drives two receivers (default buffer and a 2-pixel buffer) with the same line
// and compares their strobes against a pulse-level model of the protocol.
module tb_anton_neopixel_receiver;
    import anton_neopixel_receiver_pkg::BUFFER_END_DEFAULT;

    localparam int BIG_END   = BUFFER_END_DEFAULT;
    localparam int SMALL_END = 1;
    localparam int BITS_A    = (BIG_END + 1 <= 2) ? 1 : $clog2(BIG_END + 1);
    localparam int ONE_AT    = 4;
    localparam int HIGH_MAX  = 7;
    localparam int LATCH     = 350;

    typedef struct packed {
        logic [7:0] data;
        logic [7:0] pix;
        logic [1:0] chan;
    } byteEv_t;

    logic clk7mhz = 1'b0;
    logic rst;
    logic enable;
    logic neoDataIn;

    logic [7:0]        byteDataA, byteDataB;
    logic              byteValidA, byteValidB;
    logic [BITS_A-1:0] pixelIndexA;
    logic [0:0]        pixelIndexB;
    logic [1:0]        channelIndexA, channelIndexB;
    logic              frameDoneA, frameDoneB;
    logic              errPulseA, errPulseB;
    logic              overflowA, overflowB;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    byteEv_t gotA[$];
    byteEv_t gotB[$];
    byteEv_t expA[$];
    byteEv_t expB[$];
    int frameCycA[$];
    int errCycA[$];
    int frameCntB = 0;
    int errCntB = 0;
    int lastByteCycA = 0;

    bit         mSynced;
    int         mBits;
    logic [7:0] mShift;
    int         mByteNum;
    bit         mOvfA;
    bit         mOvfB;
    int         expFrames;
    int         expErrs;

    always #5 clk7mhz = ~clk7mhz;

    always @(posedge clk7mhz) cyc <= cyc + 1;

    anton_neopixel_receiver dutA (
        .clk7mhz      (clk7mhz),
        .rst          (rst),
        .enable       (enable),
        .neoDataIn    (neoDataIn),
        .byteData     (byteDataA),
        .byteValid    (byteValidA),
        .pixelIndex   (pixelIndexA),
        .channelIndex (channelIndexA),
        .frameDone    (frameDoneA),
        .errPulse     (errPulseA),
        .overflow     (overflowA)
    );

    anton_neopixel_receiver #(.BUFFER_END(SMALL_END)) dutB (
        .clk7mhz      (clk7mhz),
        .rst          (rst),
        .enable       (enable),
        .neoDataIn    (neoDataIn),
        .byteData     (byteDataB),
        .byteValid    (byteValidB),
        .pixelIndex   (pixelIndexB),
        .channelIndex (channelIndexB),
        .frameDone    (frameDoneB),
        .errPulse     (errPulseB),
        .overflow     (overflowB)
    );

    // Outputs are sampled on the falling edge, away from the active edge.
    always @(negedge clk7mhz) begin
        if (!rst) begin
            if (byteValidA) begin
                gotA.push_back('{byteDataA, 8'(pixelIndexA), channelIndexA});
                lastByteCycA = cyc;
            end
            if (byteValidB) gotB.push_back('{byteDataB, 8'(pixelIndexB), channelIndexB});
            if (frameDoneA) frameCycA.push_back(cyc);
            if (errPulseA) errCycA.push_back(cyc);
            if (frameDoneB) frameCntB++;
            if (errPulseB) errCntB++;
        end
    end

    task automatic checkEq(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        mSynced   = 1'b0;
        mBits     = 0;
        mShift    = '0;
        mByteNum  = 0;
        mOvfA     = 1'b0;
        mOvfB     = 1'b0;
    endtask

    // One completed high pulse as seen on the line.
    task automatic modelPulse(input int high);
        byteEv_t ev;
        if (!mSynced) return;
        if (high < 2 || high > HIGH_MAX) begin
            expErrs++;
            mSynced = 1'b0;
            mBits   = 0;
            return;
        end
        mShift = {mShift[6:0], (high >= ONE_AT) ? 1'b1 : 1'b0};
        mBits++;
        if (mBits == 8) begin
            ev = '{mShift, 8'(mByteNum / 3), 2'(mByteNum % 3)};
            if (mByteNum / 3 <= BIG_END) expA.push_back(ev); else mOvfA = 1'b1;
            if (mByteNum / 3 <= SMALL_END) expB.push_back(ev); else mOvfB = 1'b1;
            mByteNum++;
            mBits = 0;
        end
    endtask

    // A low stretch; only stretches of at least LATCH cycles matter.
    task automatic modelLow(input int n);
        if (n < LATCH) return;
        if (!mSynced) begin
            mSynced  = 1'b1;
            mByteNum = 0;
            mBits    = 0;
        end else if (mByteNum > 0 || mBits > 0) begin
            if (mBits != 0) expErrs++;
            if (mByteNum > 0) expFrames++;
            mByteNum = 0;
            mBits    = 0;
            mOvfA    = 1'b0;
            mOvfB    = 1'b0;
        end
    endtask

    task automatic lineFor(input logic level, input int n);
        neoDataIn = level;
        repeat (n) begin
            @(posedge clk7mhz);
            #1;
        end
    endtask

    task automatic lowFor(input int n);
        lineFor(1'b0, n);
        modelLow(n);
    endtask

    task automatic applyStimulus(input int high, input int low);
        lineFor(1'b1, high);
        modelPulse(high);
        lineFor(1'b0, low);
        modelLow(low);
    endtask

    task automatic sendByte(input logic [7:0] data, input bit exact);
        int high;
        int low;
        for (int i = 7; i >= 0; i--) begin
            if (exact) begin
                high = data[i] ? 5 : 2;
                low  = data[i] ? 3 : 6;
            end else begin
                high = data[i] ? int'($urandom_range(4, 7)) : int'($urandom_range(2, 3));
                low  = int'($urandom_range(1, 8));
            end
            applyStimulus(high, low);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkEq({tag, " countA"}, 32'(gotA.size()), 32'(expA.size()));
        for (int i = 0; i < expA.size() && i < gotA.size(); i++)
            checkEq($sformatf("%s byteA[%0d]", tag, i), 32'(gotA[i]), 32'(expA[i]));
        checkEq({tag, " countB"}, 32'(gotB.size()), 32'(expB.size()));
        for (int i = 0; i < expB.size() && i < gotB.size(); i++)
            checkEq($sformatf("%s byteB[%0d]", tag, i), 32'(gotB[i]), 32'(expB[i]));
        checkEq({tag, " framesA"}, 32'(frameCycA.size()), 32'(expFrames));
        checkEq({tag, " framesB"}, 32'(frameCntB), 32'(expFrames));
        checkEq({tag, " errsA"}, 32'(errCycA.size()), 32'(expErrs));
        checkEq({tag, " errsB"}, 32'(errCntB), 32'(expErrs));
        checkEq({tag, " overflowA"}, 32'(overflowA), 32'(mOvfA));
        checkEq({tag, " overflowB"}, 32'(overflowB), 32'(mOvfB));
        gotA.delete();
        gotB.delete();
        expA.delete();
        expB.delete();
        frameCycA.delete();
        errCycA.delete();
        frameCntB = 0;
        errCntB   = 0;
        expFrames = 0;
        expErrs   = 0;
    endtask

    task automatic checkLatchDelay(input string tag);
        checkEq({tag, " latch delay"},
                (frameCycA.size() == 1) ? 32'(frameCycA[0] - lastByteCycA) : 32'hFFFF_FFFF,
                32'(LATCH));
    endtask

    task automatic checkQuiet(input string tag);
        checkEq({tag, " byteValidA"}, 32'(byteValidA), 32'd0);
        checkEq({tag, " errPulseA"}, 32'(errPulseA), 32'd0);
        checkEq({tag, " frameDoneA"}, 32'(frameDoneA), 32'd0);
        checkEq({tag, " overflowA"}, 32'(overflowA), 32'd0);
        checkEq({tag, " overflowB"}, 32'(overflowB), 32'd0);
        checkEq({tag, " byteDataA"}, 32'(byteDataA), 32'd0);
        checkEq({tag, " pixelIndexA"}, 32'(pixelIndexA), 32'd0);
        checkEq({tag, " channelIndexA"}, 32'(channelIndexA), 32'd0);
    endtask

    initial begin
        logic [7:0] loopBytes [9];
        rst       = 1'b1;
        enable    = 1'b1;
        neoDataIn = 1'b0;
        expFrames = 0;
        expErrs   = 0;
        modelReset();
        loopBytes = '{8'hFF, 8'h00, 8'hD5, 8'h00, 8'h88, 8'h00, 8'h00, 8'h00, 8'h90};

        $display("[TB] reset and single byte");
        lineFor(1'b0, 3);
        checkQuiet("reset");
        rst = 1'b0;
        lowFor(350);
        sendByte(8'hA5, 1'b1);
        lowFor(20);
        checkOutput("byteA5");
        lowFor(400);
        checkLatchDelay("byteA5");
        checkOutput("byteA5 latch");

        $display("[TB] three-pixel loopback, overflow on small buffer");
        for (int i = 0; i < 9; i++) sendByte(loopBytes[i], 1'b1);
        lowFor(10);
        checkOutput("loopback");
        lowFor(400);
        checkLatchDelay("loopback");
        checkOutput("loopback latch");

        $display("[TB] glitch and overlong pulse");
        applyStimulus(5, 3);
        applyStimulus(2, 6);
        applyStimulus(4, 2);
        applyStimulus(1, 5);
        lowFor(10);
        checkOutput("glitch");
        lowFor(400);
        sendByte(8'($urandom_range(0, 255)), 1'b0);
        applyStimulus(7, 2);
        applyStimulus(3, 2);
        applyStimulus(8, 10);
        applyStimulus(20, 10);
        lowFor(10);
        checkOutput("overlong");
        lowFor(400);
        sendByte(8'($urandom_range(0, 255)), 1'b0);
        sendByte(8'($urandom_range(0, 255)), 1'b0);
        lowFor(400);
        checkOutput("after error");

        $display("[TB] random frames");
        for (int f = 0; f < 4; f++) begin
            int nBytes;
            nBytes = int'($urandom_range(1, 9));
            for (int b = 0; b < nBytes; b++) sendByte(8'($urandom_range(0, 255)), 1'b0);
            lowFor(400);
            checkLatchDelay($sformatf("random%0d", f));
            checkOutput($sformatf("random%0d", f));
        end

        $display("[TB] partial byte at latch");
        sendByte(8'($urandom_range(0, 255)), 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(int'($urandom_range(2, 7)), 4);
        lowFor(400);
        checkEq("partial err with frame",
                (errCycA.size() == 1 && frameCycA.size() == 1) ? 32'(errCycA[0] - frameCycA[0]) : 32'hFFFF_FFFF,
                32'd0);
        checkOutput("partial");

        $display("[TB] reset during a high pulse");
        for (int i = 0; i < 7; i++) sendByte(8'($urandom_range(0, 255)), 1'b0);
        lowFor(10);
        checkOutput("pre reset");
        lineFor(1'b1, 4);
        rst = 1'b1;
        lineFor(1'b1, 2);
        checkQuiet("reset in high");
        rst = 1'b0;
        modelReset();
        lineFor(1'b1, 3);
        lineFor(1'b0, 5);
        lowFor(200);
        sendByte(8'($urandom_range(0, 255)), 1'b0);
        lowFor(20);
        checkOutput("reset no decode");
        lowFor(400);
        sendByte(8'($urandom_range(0, 255)), 1'b0);
        lowFor(400);
        checkOutput("reset resync");

        $display("[TB] enable dropped mid-byte");
        applyStimulus(5, 3);
        applyStimulus(2, 6);
        applyStimulus(6, 3);
        lowFor(5);
        enable = 1'b0;
        mSynced = 1'b0;
        mBits   = 0;
        lowFor(20);
        enable = 1'b1;
        lowFor(200);
        sendByte(8'($urandom_range(0, 255)), 1'b0);
        lowFor(20);
        checkOutput("disable no decode");
        lowFor(400);
        sendByte(8'($urandom_range(0, 255)), 1'b0);
        lowFor(400);
        checkOutput("disable resync");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
